// File: rtl/cmp_monitor_pkg.sv
// Shared types and constants for the reference/DUT mismatch monitor.
package cmp_monitor_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    localparam logic [CNT_W_DEFAULT-1:0] NO_ERR_IDX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cmp_mismatch_monitor.sv
// Compares reference and DUT outputs per valid sample, counts mismatches, reports pass/fail.
// Optional first-mismatch data capture: define CMP_MISMATCH_CAPTURE_EN.
module cmp_mismatch_monitor
    import cmp_monitor_pkg::*;
#(
    parameter int unsigned DATA_W      = 1,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned N_SAMPLES   = 100,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              valid,
    input  logic [DATA_W-1:0] ref_data,
    input  logic [DATA_W-1:0] dut_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  samples,
    output logic [CNT_W-1:0]  errors,
    output logic [CNT_W-1:0]  first_err_idx,
`ifdef CMP_MISMATCH_CAPTURE_EN
    output logic [DATA_W-1:0] first_err_ref,
    output logic [DATA_W-1:0] first_err_dut,
`endif
    output logic              pass
);

    localparam logic [63:0] N_SAMP_L   = 64'(N_SAMPLES);
    localparam logic [63:0] TIMEOUT_L  = 64'(TIMEOUT_CYC) - 64'd1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   samples_q, errors_q, cyc_q;
    logic [CNT_W-1:0]   samp_post;
    logic [CNT_W-1:0]   first_idx_q, first_idx_d;
    logic               timeout_q, timeout_d;
    logic               clr, samp_inc, err_inc, cyc_inc;
    logic               mismatch;
    logic               capture;

    sat_counter #(.W(CNT_W)) u_samples (
        .clk(clk), .reset(reset), .clr(clr), .inc(samp_inc), .q(samples_q)
    );
    sat_counter #(.W(CNT_W)) u_errors (
        .clk(clk), .reset(reset), .clr(clr), .inc(err_inc), .q(errors_q)
    );
    sat_counter #(.W(CNT_W)) u_cycles (
        .clk(clk), .reset(reset), .clr(clr), .inc(cyc_inc), .q(cyc_q)
    );

    always_comb begin
        state_d     = state_q;
        clr         = 1'b0;
        samp_inc    = 1'b0;
        err_inc     = 1'b0;
        cyc_inc     = 1'b0;
        capture     = 1'b0;
        first_idx_d = first_idx_q;
        timeout_d   = timeout_q;
        mismatch    = valid && (ref_data != dut_data);
        samp_post   = (samples_q != '1) ? samples_q + 1'b1 : samples_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    clr         = 1'b1;
                    first_idx_d = '1;
                    timeout_d   = 1'b0;
                end
            end
            RUN: begin
                cyc_inc = 1'b1;
                if (N_SAMPLES == 0) begin
                    state_d = DONE;
                end else begin
                    samp_inc = valid;
                    err_inc  = mismatch;
                    if (mismatch && (errors_q == '0)) begin
                        first_idx_d = samples_q;
                        capture     = 1'b1;
                    end
                    // Sample-count exit outranks timeout when both land on one edge.
                    if (valid && (64'(samp_post) == N_SAMP_L)) begin
                        state_d = DONE;
                    end else if (64'(cyc_q) == TIMEOUT_L) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            first_idx_q <= '1;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_idx_q <= first_idx_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef CMP_MISMATCH_CAPTURE_EN
    logic [DATA_W-1:0] cap_ref_q, cap_dut_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cap_ref_q <= '0;
            cap_dut_q <= '0;
        end else if (capture) begin
            cap_ref_q <= ref_data;
            cap_dut_q <= dut_data;
        end
    end

    assign first_err_ref = cap_ref_q;
    assign first_err_dut = cap_dut_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign timeout       = timeout_q;
    assign samples       = samples_q;
    assign errors        = errors_q;
    assign first_err_idx = first_idx_q;
    assign pass          = done && (errors_q == '0) && !timeout_q;

endmodule

// File: tb/tb_cmp_mismatch_monitor.sv
// Directed self-checking bench for cmp_mismatch_monitor across several parameter sets.
module tb_cmp_mismatch_monitor;
    import cmp_monitor_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: default counts, 8-bit data
    logic        a_start, a_valid, a_busy, a_done, a_timeout, a_pass;
    logic [7:0]  a_ref, a_dut;
    logic [31:0] a_samples, a_errors, a_idx;
`ifdef CMP_MISMATCH_CAPTURE_EN
    logic [7:0]  a_cref, a_cdut;
`endif
    // B: short timeout
    logic        b_start, b_valid, b_busy, b_done, b_timeout, b_pass;
    logic [0:0]  b_ref, b_dut;
    logic [31:0] b_samples, b_errors, b_idx;
`ifdef CMP_MISMATCH_CAPTURE_EN
    logic [0:0]  b_cref, b_cdut;
`endif
    // C: sample and timeout exits coincide
    logic        c_start, c_valid, c_busy, c_done, c_timeout, c_pass;
    logic [0:0]  c_ref, c_dut;
    logic [31:0] c_samples, c_errors, c_idx;
`ifdef CMP_MISMATCH_CAPTURE_EN
    logic [0:0]  c_cref, c_cdut;
`endif
    // D: 3-bit counters for saturation
    logic        d_start, d_valid, d_busy, d_done, d_timeout, d_pass;
    logic [0:0]  d_ref, d_dut;
    logic [2:0]  d_samples, d_errors, d_idx;
`ifdef CMP_MISMATCH_CAPTURE_EN
    logic [0:0]  d_cref, d_cdut;
`endif
    // E: zero-sample run
    logic        e_start, e_valid, e_busy, e_done, e_timeout, e_pass;
    logic [0:0]  e_ref, e_dut;
    logic [31:0] e_samples, e_errors, e_idx;
`ifdef CMP_MISMATCH_CAPTURE_EN
    logic [0:0]  e_cref, e_cdut;
`endif

    cmp_mismatch_monitor #(.DATA_W(8)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .valid(a_valid),
        .ref_data(a_ref), .dut_data(a_dut), .busy(a_busy), .done(a_done),
        .timeout(a_timeout), .samples(a_samples), .errors(a_errors),
        .first_err_idx(a_idx),
`ifdef CMP_MISMATCH_CAPTURE_EN
        .first_err_ref(a_cref), .first_err_dut(a_cdut),
`endif
        .pass(a_pass)
    );

    cmp_mismatch_monitor #(.TIMEOUT_CYC(20)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .valid(b_valid),
        .ref_data(b_ref), .dut_data(b_dut), .busy(b_busy), .done(b_done),
        .timeout(b_timeout), .samples(b_samples), .errors(b_errors),
        .first_err_idx(b_idx),
`ifdef CMP_MISMATCH_CAPTURE_EN
        .first_err_ref(b_cref), .first_err_dut(b_cdut),
`endif
        .pass(b_pass)
    );

    cmp_mismatch_monitor #(.N_SAMPLES(5), .TIMEOUT_CYC(5)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .valid(c_valid),
        .ref_data(c_ref), .dut_data(c_dut), .busy(c_busy), .done(c_done),
        .timeout(c_timeout), .samples(c_samples), .errors(c_errors),
        .first_err_idx(c_idx),
`ifdef CMP_MISMATCH_CAPTURE_EN
        .first_err_ref(c_cref), .first_err_dut(c_cdut),
`endif
        .pass(c_pass)
    );

    cmp_mismatch_monitor #(.CNT_W(3), .N_SAMPLES(20)) u_d (
        .clk(clk), .reset(reset), .start(d_start), .valid(d_valid),
        .ref_data(d_ref), .dut_data(d_dut), .busy(d_busy), .done(d_done),
        .timeout(d_timeout), .samples(d_samples), .errors(d_errors),
        .first_err_idx(d_idx),
`ifdef CMP_MISMATCH_CAPTURE_EN
        .first_err_ref(d_cref), .first_err_dut(d_cdut),
`endif
        .pass(d_pass)
    );

    cmp_mismatch_monitor #(.N_SAMPLES(0)) u_e (
        .clk(clk), .reset(reset), .start(e_start), .valid(e_valid),
        .ref_data(e_ref), .dut_data(e_dut), .busy(e_busy), .done(e_done),
        .timeout(e_timeout), .samples(e_samples), .errors(e_errors),
        .first_err_idx(e_idx),
`ifdef CMP_MISMATCH_CAPTURE_EN
        .first_err_ref(e_cref), .first_err_dut(e_cdut),
`endif
        .pass(e_pass)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", a_done); end
        n_checks++; if (a_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", a_timeout); end
        n_checks++; if (a_samples !== 32'd0) begin n_fail++; $display("FAIL reset_samples: got %0d want 0", a_samples); end
        n_checks++; if (a_errors !== 32'd0) begin n_fail++; $display("FAIL reset_errors: got %0d want 0", a_errors); end
        n_checks++; if (a_idx !== NO_ERR_IDX) begin n_fail++; $display("FAIL reset_idx: got %h want %h", a_idx, NO_ERR_IDX); end
        n_checks++; if (a_pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", a_pass); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_idle_ignore();
        a_valid = 1'b1; a_ref = 8'h01; a_dut = 8'h02;
        step(3);
        n_checks++; if (a_samples !== 32'd0) begin n_fail++; $display("FAIL idle_samples: got %0d want 0", a_samples); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", a_busy); end
        a_valid = 1'b0;
    endtask

    task automatic test_clean();
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy: got %b want 1", a_busy); end
        for (int i = 0; i < 100; i++) begin
            a_valid = 1'b1; a_ref = 8'(i); a_dut = 8'(i);
            step(1);
            if (i == 98) begin
                n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL clean_early_done: got %b want 0", a_done); end
            end
        end
        n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %b want 1", a_done); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy_end: got %b want 0", a_busy); end
        n_checks++; if (a_samples !== 32'd100) begin n_fail++; $display("FAIL clean_samples: got %0d want 100", a_samples); end
        n_checks++; if (a_errors !== 32'd0) begin n_fail++; $display("FAIL clean_errors: got %0d want 0", a_errors); end
        n_checks++; if (a_idx !== NO_ERR_IDX) begin n_fail++; $display("FAIL clean_idx: got %h want %h", a_idx, NO_ERR_IDX); end
        n_checks++; if (a_pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b want 1", a_pass); end
        n_checks++; if (a_timeout !== 1'b0) begin n_fail++; $display("FAIL clean_timeout: got %b want 0", a_timeout); end
        a_valid = 1'b1; a_ref = 8'h11; a_dut = 8'h22;
        step(3);
        n_checks++; if (a_samples !== 32'd100) begin n_fail++; $display("FAIL done_frozen_samples: got %0d want 100", a_samples); end
        n_checks++; if (a_errors !== 32'd0) begin n_fail++; $display("FAIL done_frozen_errors: got %0d want 0", a_errors); end
        a_valid = 1'b0;
    endtask

    task automatic test_first_mismatch();
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", a_busy); end
        n_checks++; if (a_samples !== 32'd0) begin n_fail++; $display("FAIL restart_samples: got %0d want 0", a_samples); end
        n_checks++; if (a_idx !== NO_ERR_IDX) begin n_fail++; $display("FAIL restart_idx: got %h want %h", a_idx, NO_ERR_IDX); end
        for (int i = 0; i < 100; i++) begin
            a_valid = 1'b1;
            a_ref   = 8'(i);
            a_dut   = (i == 7 || i == 8 || i == 50) ? (8'(i) ^ 8'hA5) : 8'(i);
            a_start = (i == 20);
            step(1);
            if (i == 7) begin
                n_checks++; if (a_errors !== 32'd1) begin n_fail++; $display("FAIL mm_errors_at7: got %0d want 1", a_errors); end
                n_checks++; if (a_idx !== 32'd7) begin n_fail++; $display("FAIL mm_idx_at7: got %0d want 7", a_idx); end
            end
            if (i == 20) begin
                n_checks++; if (a_samples !== 32'd21) begin n_fail++; $display("FAIL start_in_run_samples: got %0d want 21", a_samples); end
                n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL start_in_run_busy: got %b want 1", a_busy); end
            end
        end
        a_start = 1'b0; a_valid = 1'b0;
        n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL mm_done: got %b want 1", a_done); end
        n_checks++; if (a_errors !== 32'd3) begin n_fail++; $display("FAIL mm_errors: got %0d want 3", a_errors); end
        n_checks++; if (a_idx !== 32'd7) begin n_fail++; $display("FAIL mm_idx: got %0d want 7", a_idx); end
        n_checks++; if (a_pass !== 1'b0) begin n_fail++; $display("FAIL mm_pass: got %b want 0", a_pass); end
`ifdef CMP_MISMATCH_CAPTURE_EN
        n_checks++; if (a_cref !== 8'h07) begin n_fail++; $display("FAIL mm_cap_ref: got %h want 07", a_cref); end
        n_checks++; if (a_cdut !== 8'hA2) begin n_fail++; $display("FAIL mm_cap_dut: got %h want a2", a_cdut); end
`endif
    endtask

    task automatic test_midrun_reset();
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a_valid = 1'b1; a_ref = 8'(i); a_dut = (i == 3) ? 8'hFF : 8'(i);
            step(1);
        end
        n_checks++; if (a_errors !== 32'd1) begin n_fail++; $display("FAIL midrun_pre_errors: got %0d want 1", a_errors); end
        reset = 1'b1; a_valid = 1'b0;
        step(1);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL midrun_done: got %b want 0", a_done); end
        n_checks++; if (a_samples !== 32'd0) begin n_fail++; $display("FAIL midrun_samples: got %0d want 0", a_samples); end
        n_checks++; if (a_errors !== 32'd0) begin n_fail++; $display("FAIL midrun_errors: got %0d want 0", a_errors); end
        n_checks++; if (a_idx !== NO_ERR_IDX) begin n_fail++; $display("FAIL midrun_idx: got %h want %h", a_idx, NO_ERR_IDX); end
`ifdef CMP_MISMATCH_CAPTURE_EN
        n_checks++; if (a_cref !== 8'h00 || a_cdut !== 8'h00) begin n_fail++; $display("FAIL midrun_cap: got %h/%h want 00/00", a_cref, a_cdut); end
`endif
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_timeout();
        b_start = 1'b1;
        step(1);
        b_start = 1'b0;
        step(19);
        n_checks++; if (b_done !== 1'b0 || b_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got done=%b busy=%b want 0/1", b_done, b_busy); end
        step(1);
        n_checks++; if (b_done !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got %b want 1", b_done); end
        n_checks++; if (b_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", b_timeout); end
        n_checks++; if (b_samples !== 32'd0) begin n_fail++; $display("FAIL tmo_samples: got %0d want 0", b_samples); end
        n_checks++; if (b_pass !== 1'b0) begin n_fail++; $display("FAIL tmo_pass: got %b want 0", b_pass); end
    endtask

    task automatic test_simultaneous();
        c_start = 1'b1;
        step(1);
        c_start = 1'b0;
        c_valid = 1'b1; c_ref = 1'b0; c_dut = 1'b0;
        step(4);
        n_checks++; if (c_done !== 1'b0 || c_samples !== 32'd4) begin n_fail++; $display("FAIL sim_early: got done=%b samples=%0d want 0/4", c_done, c_samples); end
        step(1);
        c_valid = 1'b0;
        n_checks++; if (c_done !== 1'b1) begin n_fail++; $display("FAIL sim_done: got %b want 1", c_done); end
        n_checks++; if (c_timeout !== 1'b0) begin n_fail++; $display("FAIL sim_timeout: got %b want 0", c_timeout); end
        n_checks++; if (c_samples !== 32'd5) begin n_fail++; $display("FAIL sim_samples: got %0d want 5", c_samples); end
        n_checks++; if (c_pass !== 1'b1) begin n_fail++; $display("FAIL sim_pass: got %b want 1", c_pass); end
    endtask

    task automatic test_saturation();
        d_start = 1'b1;
        step(1);
        d_start = 1'b0;
        d_valid = 1'b1; d_ref = 1'b0; d_dut = 1'b1;
        step(25);
        d_valid = 1'b0;
        n_checks++; if (d_samples !== 3'd7) begin n_fail++; $display("FAIL sat_samples: got %0d want 7", d_samples); end
        n_checks++; if (d_errors !== 3'd7) begin n_fail++; $display("FAIL sat_errors: got %0d want 7", d_errors); end
        n_checks++; if (d_done !== 1'b0 || d_busy !== 1'b1) begin n_fail++; $display("FAIL sat_state: got done=%b busy=%b want 0/1", d_done, d_busy); end
        n_checks++; if (d_idx !== 3'd0) begin n_fail++; $display("FAIL sat_idx: got %0d want 0", d_idx); end
    endtask

    task automatic test_zero_samples();
        e_start = 1'b1;
        step(1);
        e_start = 1'b0;
        n_checks++; if (e_busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", e_busy); end
        e_valid = 1'b1; e_ref = 1'b0; e_dut = 1'b1;
        step(1);
        e_valid = 1'b0;
        n_checks++; if (e_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", e_done); end
        n_checks++; if (e_samples !== 32'd0 || e_errors !== 32'd0) begin n_fail++; $display("FAIL zero_counts: got %0d/%0d want 0/0", e_samples, e_errors); end
        n_checks++; if (e_pass !== 1'b1) begin n_fail++; $display("FAIL zero_pass: got %b want 1", e_pass); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        a_start = 1'b0; a_valid = 1'b0; a_ref = '0; a_dut = '0;
        b_start = 1'b0; b_valid = 1'b0; b_ref = '0; b_dut = '0;
        c_start = 1'b0; c_valid = 1'b0; c_ref = '0; c_dut = '0;
        d_start = 1'b0; d_valid = 1'b0; d_ref = '0; d_dut = '0;
        e_start = 1'b0; e_valid = 1'b0; e_ref = '0; e_dut = '0;
        test_reset();
        test_idle_ignore();
        test_clean();
        test_first_mismatch();
        test_midrun_reset();
        test_timeout();
        test_simultaneous();
        test_saturation();
        test_zero_samples();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_mismatch_monitor.md
Name: cmp_mismatch_monitor

Overview:
- Response-side counterpart to the stimulus generator: samples a reference output and a DUT output on every valid cycle and compares them.
- Counts samples and mismatches, and records the sample index of the first mismatch.
- Ends the run after a fixed sample count or a timeout and reports pass/fail.
- Sits next to the reference model and the DUT in hardware self-check harnesses. It replaces the simulation-only mismatch bookkeeping.

Parameters:
- DATA_W, 1, width of the compared reference/DUT output vectors.
- CNT_W, 32, width of every counter and count output.
- N_SAMPLES, 100, valid samples per run before DONE.
- TIMEOUT_CYC, 100000, maximum clock cycles spent in RUN before a forced DONE.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- valid  in  1  ref_data and dut_data are a sample this cycle.
- ref_data  in  DATA_W  reference model output.
- dut_data  in  DATA_W  DUT output.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- timeout  out  1  run ended by TIMEOUT_CYC, not by N_SAMPLES.
- samples  out  CNT_W  valid samples taken this run.
- errors  out  CNT_W  mismatching samples this run.
- first_err_idx  out  CNT_W  zero-based sample index of the first mismatch; all-ones if there was none.
- pass  out  1  done && errors==0 && !timeout.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, timeout=0, samples=0, errors=0, first_err_idx=all-ones, pass=0; internal cycle counter 0.
- Register rule: all outputs are registered. Effects of a sample or start are visible the cycle after the triggering edge.
- State IDLE:
  - start=1 clears all counters, first_err_idx=all-ones and timeout; goes to RUN.
  - valid is ignored in IDLE.
- State RUN:
  - busy=1. The cycle counter increments every cycle.
  - On valid: mismatch = (ref_data != dut_data), compared bitwise over all DATA_W bits.
  - samples increments on every valid sample.
  - errors increments when mismatch=1.
  - If mismatch=1 and errors==0 before this sample, first_err_idx gets the pre-increment samples value.
- RUN exits, in priority order:
  - samples reaching N_SAMPLES (post-increment) goes to DONE with timeout=0.
  - Otherwise, cycle counter reaching TIMEOUT_CYC-1 goes to DONE with timeout=1.
  - If both occur in the same cycle, the sample-count exit wins and timeout=0.
  - The sample that completes the run is counted and compared.
- start while in RUN is ignored; there is no restart mid-run.
- State DONE:
  - done=1, outputs frozen, valid ignored.
  - start=1 clears counters and goes to RUN, exactly as from IDLE.
- Counter saturation: samples, errors and the cycle counter hold at all-ones and never wrap.
- N_SAMPLES=0: the first RUN cycle goes to DONE with samples=0 and pass=1.
- reset in any state, including mid-run, returns every output to its reset value on the next edge.
- X/Z on the inputs is not modelled; comparison is plain inequality.

Optional Feature:
- Macro: CMP_MISMATCH_CAPTURE_EN.
- Defined:
  - Adds outputs first_err_ref[DATA_W] and first_err_dut[DATA_W].
  - They latch ref_data and dut_data on the same edge that writes first_err_idx.
  - Reset and start clear them to 0.
  - After a capture they hold until the next start or reset.
- Undefined: those ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package cmp_monitor_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2-bit encoding;
  - constant NO_ERR_IDX (all-ones of CNT_W);
  - the default CNT_W.
- Sub-module sat_counter: parameter W; ports clk, reset, clr, inc, q.
  - Increments when inc=1, holds at all-ones, clears on clr, and clr has priority over inc.
  - Instantiated three times: samples, errors, cycle counter.

Test Plan:
- Clean run: reset, start, then 100 valid samples with ref==dut -> done=1, samples=100, errors=0, first_err_idx=all-ones, pass=1, timeout=0.
- First mismatch: mismatches injected at samples 7, 8 and 50 -> errors=3, first_err_idx=7, pass=0. With CMP_MISMATCH_CAPTURE_EN: first_err_ref/first_err_dut hold the sample-7 values.
- Timeout: TIMEOUT_CYC=20, valid held low after start -> done=1 exactly 20 cycles after entering RUN, timeout=1, samples=0, pass=0.
- Simultaneous exit: N_SAMPLES=5, TIMEOUT_CYC=5, valid high every cycle -> done with timeout=0, samples=5.
- Mid-run reset and restart: reset asserted after 40 samples -> all outputs at reset values next cycle. Separately, start pulsed in DONE -> counters cleared, busy=1 next cycle. Start pulsed during RUN -> no effect.
- Saturation: CNT_W=3, N_SAMPLES=20, all samples mismatch -> samples=7 and errors=7 held, with no wrap and no spurious DONE.
